dht11_temp_reader: RTL and testbench



---
 rtl/dht11_temp_reader.sv | 95 +++++++++
 tb/tb_dht11_temp_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_temp_reader.sv
// dht11_temp_reader: single-wire DHT11-class sensor reader; periodic start pulse, 40-bit frame decode, checksum validation
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   dq_in        in   raw data-line level, asynchronous to clk
//   dq_drive_low out  1 = pull the line low, 0 = release it
//   tempV        out  last valid integer temperature, degrees C
//   humidity     out  last valid integer relative humidity, %
//   valid        out  one-cycle pulse coincident with a tempV/humidity update
//   error        out  sticky timeout/checksum flag, cleared by the next good frame
//   busy         out  high from start pulse until back in IDLE
module dht11_temp_reader #(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned START_LOW_US     = 18000,
    parameter int unsigned SAMPLE_PERIOD_US = 1_000_000,
    parameter int unsigned BIT_THRESH_US    = 50,
    parameter int unsigned TIMEOUT_US       = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dq_in,
    output logic       dq_drive_low,
    output logic [7:0] tempV,
    output logic [7:0] humidity,
    output logic       valid,
    output logic       error,
    output logic       busy
);
    localparam int unsigned DIV = CLK_HZ / 1_000_000;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    typedef enum logic [2:0] {IDLE, START, REL, RESP_L, RESP_H, BIT_L, BIT_H, CHECK} state_t;
    state_t state, next;
    logic [DW-1:0] div_cnt;
    logic us_tick, timeout, shift, fail, sum_ok;
    logic [31:0] us_cnt, cnt_nxt;
    logic dq_m, dq_s, dq_d;
    logic [39:0] frame;
    logic [5:0] idx;
    assign us_tick = div_cnt == DIV_LAST;
    // Every limit is tested against the value the timer reaches on this tick,
    // so a phase lasting N us is measured as exactly N.
    assign cnt_nxt = us_cnt + 32'(us_tick);
    assign timeout = cnt_nxt >= TIMEOUT_US;
    assign sum_ok  = frame[7:0] == frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next  = state;
        shift = 1'b0;
        case (state)
            IDLE:   next = (cnt_nxt >= SAMPLE_PERIOD_US) ? START : IDLE;
            START:  next = (cnt_nxt >= START_LOW_US) ? REL : START;
            // Our own start pulse is still draining out of the synchronizer on
            // entry, so the sensor's response is taken as a falling edge.
            REL:    next = (dq_d && !dq_s) ? RESP_L : timeout ? IDLE : REL;
            RESP_L: next = dq_s ? RESP_H : timeout ? IDLE : RESP_L;
            RESP_H: next = !dq_s ? BIT_L : timeout ? IDLE : RESP_H;
            BIT_L:  next = dq_s ? BIT_H : timeout ? IDLE : BIT_L;
            BIT_H: begin
                shift = !dq_s;
                next  = !dq_s ? ((idx == 6'd39) ? CHECK : BIT_L) : timeout ? IDLE : BIT_H;
            end
            CHECK:  next = IDLE;
        endcase
        fail         = (state inside {REL, RESP_L, RESP_H, BIT_L, BIT_H}) && next == IDLE;
        dq_drive_low = state == START;
        busy         = state != IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {dq_m, dq_s, dq_d} <= 3'b111;
            div_cnt  <= '0;
            us_cnt   <= '0;
            frame    <= '0;
            idx      <= '0;
            tempV    <= '0;
            humidity <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
        end else begin
            {dq_m, dq_s, dq_d} <= {dq_in, dq_m, dq_s};
            div_cnt <= us_tick ? '0 : div_cnt + DW'(1);
            us_cnt  <= (next != state) ? '0 : cnt_nxt;
            idx     <= shift ? idx + 6'd1 : (state == RESP_H) ? 6'd0 : idx;
            if (shift) frame <= {frame[38:0], cnt_nxt > BIT_THRESH_US};
            valid <= state == CHECK && sum_ok;
            if (state == CHECK && sum_ok) begin
                humidity <= frame[39:32];
                tempV    <= frame[23:16];
            end
            error <= (fail || (state == CHECK && !sum_ok)) ? 1'b1 : (state == CHECK) ? 1'b0 : error;
        end
    end
endmodule

// File: tb/tb_dht11_temp_reader.sv
// tb_dht11_temp_reader: randomized self-checking bench with a behavioural DHT11 sensor and frame model
module tb_dht11_temp_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_low = 1'b0;
    logic dq_in, dq_drive_low, valid, error, busy;
    logic [7:0] tempV, humidity;
    logic [7:0] exp_temp = 8'h00, exp_hum = 8'h00;
    logic exp_err = 1'b0;
    int tests = 0, fails = 0, vcnt = 0;

    // wired-AND line: either side may pull low, pull-up otherwise
    assign dq_in = !(dq_drive_low || sensor_low);

    dht11_temp_reader #(.CLK_HZ(1_000_000), .START_LOW_US(20), .SAMPLE_PERIOD_US(100),
                        .BIT_THRESH_US(50), .TIMEOUT_US(200)) dut (
        .clk(clk), .reset(reset), .dq_in(dq_in), .dq_drive_low(dq_drive_low),
        .tempV(tempV), .humidity(humidity), .valid(valid), .error(error), .busy(busy));

    always #5 clk = ~clk;
    always @(negedge clk) if (valid === 1'b1) vcnt++;

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit expired, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // frame model: checksum is the byte sum modulo 256; a good frame publishes B0/B2
    function automatic bit model(input logic [39:0] f);
        int s;
        bit good;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        good = (s % 256) == int'(f[7:0]);
        if (good) begin
            exp_hum = f[39:32];
            exp_temp = f[23:16];
            exp_err = 1'b0;
        end else exp_err = 1'b1;
        return good;
    endfunction

    function automatic logic [39:0] rnd_frame(input bit good);
        logic [7:0] b0, b1, b2, b3, s;
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        s = b0 + b1 + b2 + b3;
        return {b0, b1, b2, b3, good ? s : s + 8'($urandom_range(1, 255))};
    endfunction

    // waits for a start pulse to begin and end; returns at the first negedge with the line released
    task automatic catch_start();
        int n;
        n = 0;
        while (dq_drive_low !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (dq_drive_low !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        tests++;
        if (n >= 400) begin fails++; $display("FAIL catch_start: waited %0d cycles, required < 400", n); end
    endtask

    // sensor reply: 30 us turnaround, 80/80 us response, 50 us low + hi0/hi1 high per bit
    task automatic reply(input logic [39:0] f, input int hi0, input int hi1, input int abort_bit);
        repeat (30) @(negedge clk);
        sensor_low = 1'b1; repeat (80) @(negedge clk);
        sensor_low = 1'b0; repeat (80) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            sensor_low = 1'b1; repeat (50) @(negedge clk);
            sensor_low = 1'b0;
            if (i == abort_bit) begin repeat (10) @(negedge clk); return; end
            repeat (f[39-i] ? hi1 : hi0) @(negedge clk);
        end
        sensor_low = 1'b1; repeat (50) @(negedge clk);
        sensor_low = 1'b0; repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({dq_drive_low, busy, valid, error, tempV, humidity} !== 20'h0) begin
            fails++;
            $display("FAIL reset_values: drv=%b busy=%b valid=%b err=%b temp=%h hum=%h, required all 0", dq_drive_low, busy, valid, error, tempV, humidity);
        end
    endtask

    task automatic test_first_start();
        int n, w, v0;
        bit busy_low, good;
        logic [39:0] f;
        n = 0; w = 0; busy_low = 0;
        reset = 1'b1;
        while (dq_drive_low !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        tests++;
        if (n != 100) begin fails++; $display("FAIL start_delay: %0d cycles, required 100", n); end
        while (dq_drive_low === 1'b1 && w < 100) begin
            if (busy !== 1'b1) busy_low = 1;
            @(negedge clk); w++;
        end
        tests++;
        if (w != 20) begin fails++; $display("FAIL start_width: %0d cycles, required 20", w); end
        tests++;
        if (busy_low) begin fails++; $display("FAIL busy_in_start: busy dropped to 0, required 1"); end
        f = {8'h28, 8'h00, 8'h37, 8'h00, 8'h5F};
        v0 = vcnt;
        reply(f, 27, 70, -1);
        good = model(f);
        tests++;
        if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
            fails++;
            $display("FAIL good_frame: temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", tempV, humidity, error, exp_temp, exp_hum, exp_err);
        end
        tests++;
        if (vcnt - v0 != (good ? 1 : 0)) begin fails++; $display("FAIL good_valid: %0d pulses, required %0d", vcnt - v0, good ? 1 : 0); end
    endtask

    task automatic test_bad_checksum();
        int v0;
        bit good;
        logic [39:0] f;
        f = {8'h28, 8'h00, 8'h37, 8'h00, 8'h60};
        v0 = vcnt;
        catch_start();
        reply(f, 27, 70, -1);
        good = model(f);
        tests++;
        if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
            fails++;
            $display("FAIL bad_checksum: temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", tempV, humidity, error, exp_temp, exp_hum, exp_err);
        end
        tests++;
        if (vcnt - v0 != (good ? 1 : 0)) begin fails++; $display("FAIL bad_valid: %0d pulses, required %0d", vcnt - v0, good ? 1 : 0); end
    endtask

    task automatic test_timeout();
        int n, v0;
        bit good;
        logic [39:0] f;
        catch_start();
        n = 0;
        while (busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
        tests++;
        if (n != 200) begin fails++; $display("FAIL timeout_delay: busy fell after %0d cycles, required 200", n); end
        exp_err = 1'b1;
        tests++;
        if (error !== exp_err) begin fails++; $display("FAIL timeout_error: err=%b, required %b", error, exp_err); end
        n = 0;
        while (dq_drive_low !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        tests++;
        if (n != 100) begin fails++; $display("FAIL retry_delay: %0d cycles, required 100", n); end
        f = {8'h1E, 8'h00, 8'h32, 8'h00, 8'h50};
        v0 = vcnt;
        catch_start();
        reply(f, 27, 70, -1);
        good = model(f);
        tests++;
        if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
            fails++;
            $display("FAIL recover_frame: temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", tempV, humidity, error, exp_temp, exp_hum, exp_err);
        end
        tests++;
        if (vcnt - v0 != (good ? 1 : 0)) begin fails++; $display("FAIL recover_valid: %0d pulses, required %0d", vcnt - v0, good ? 1 : 0); end
    endtask

    task automatic test_random();
        int v0, hi0, hi1;
        bit good;
        logic [39:0] f;
        for (int k = 0; k < 4; k++) begin
            f = rnd_frame(1'($urandom_range(0, 1)));
            hi0 = $urandom_range(20, 50);
            hi1 = $urandom_range(51, 80);
            v0 = vcnt;
            catch_start();
            reply(f, hi0, hi1, -1);
            good = model(f);
            tests++;
            if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
                fails++;
                $display("FAIL random_frame %0d (%h): temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", k, f, tempV, humidity, error, exp_temp, exp_hum, exp_err);
            end
            tests++;
            if (vcnt - v0 != (good ? 1 : 0)) begin fails++; $display("FAIL random_valid %0d: %0d pulses, required %0d", k, vcnt - v0, good ? 1 : 0); end
        end
    endtask

    task automatic test_boundary();
        int v0;
        bit good;
        logic [39:0] f;
        for (int k = 0; k < 2; k++) begin
            f = (k == 0) ? {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC} : rnd_frame(1'b1);
            v0 = vcnt;
            catch_start();
            reply(f, 50, 51, -1);
            good = model(f);
            tests++;
            if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
                fails++;
                $display("FAIL boundary_frame %0d (%h): temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", k, f, tempV, humidity, error, exp_temp, exp_hum, exp_err);
            end
            tests++;
            if (vcnt - v0 != (good ? 1 : 0)) begin fails++; $display("FAIL boundary_valid %0d: %0d pulses, required %0d", k, vcnt - v0, good ? 1 : 0); end
        end
    endtask

    task automatic test_reset_mid();
        int n, v0;
        bit good;
        logic [39:0] f;
        catch_start();
        reply(rnd_frame(1'b1), 27, 70, 20);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_bit20: busy=%b, required 1", busy); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({dq_drive_low, busy} !== 2'b00) begin fails++; $display("FAIL async_reset_bit: drv=%b busy=%b, required 0 0", dq_drive_low, busy); end
        exp_temp = 8'h00; exp_hum = 8'h00; exp_err = 1'b0;
        sensor_low = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        tests++;
        if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
            fails++;
            $display("FAIL reset_mid_values: temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", tempV, humidity, error, exp_temp, exp_hum, exp_err);
        end
        n = 0;
        while (dq_drive_low !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        tests++;
        if (n != 100) begin fails++; $display("FAIL restart_delay: %0d cycles, required 100", n); end
        f = rnd_frame(1'b0);
        v0 = vcnt;
        catch_start();
        reply(f, 27, 70, -1);
        good = model(f);
        tests++;
        if ({tempV, humidity, error} !== {exp_temp, exp_hum, exp_err}) begin
            fails++;
            $display("FAIL bad_after_reset: temp=%h hum=%h err=%b, required temp=%h hum=%h err=%b", tempV, humidity, error, exp_temp, exp_hum, exp_err);
        end
        tests++;
        if (vcnt - v0 != (good ? 1 : 0)) begin fails++; $display("FAIL bad_after_reset_valid: %0d pulses, required %0d", vcnt - v0, good ? 1 : 0); end
        n = 0;
        while (dq_drive_low !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        tests++;
        if (dq_drive_low !== 1'b1) begin fails++; $display("FAIL drive_in_start: drv=%b, required 1", dq_drive_low); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({dq_drive_low, busy} !== 2'b00) begin fails++; $display("FAIL async_reset_start: drv=%b busy=%b, required 0 0", dq_drive_low, busy); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_start();
        test_bad_checksum();
        test_timeout();
        test_random();
        test_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
